// File: rtl/ge_tobytes.sv
// Ed25519 point compression: (X:Y:Z) -> 32-byte encoding of Y/Z with the sign of X/Z in bit 255.
// Field elements are 10 x 32-bit limb slots at radix 2^25.5 (weights 0,26,51,...,230).
package ge_fe_pkg;
  localparam logic [255:0] FE_P   = (256'd1 << 255) - 256'd19;
  localparam logic [319:0] FE_ONE = 320'd1;

  function automatic int unsigned fe_weight(input int unsigned i);
    case (i)
      0: return 0;
      1: return 26;
      2: return 51;
      3: return 77;
      4: return 102;
      5: return 128;
      6: return 153;
      7: return 179;
      8: return 204;
      default: return 230;
    endcase
  endfunction

  // Full reduction mod p of an arbitrary (unreduced) limb vector; result < p.
  function automatic logic [255:0] fe_tobytes(input logic [319:0] f);
    logic [269:0] acc;
    logic [255:0] a;
    logic [255:0] b;
    acc = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      acc = acc + (270'(f[32*i +: 32]) << fe_weight(i));
    end
    a = 256'(acc[254:0]) + 256'(acc[269:255]) * 256'd19;
    b = 256'(a[254:0]) + (a[255] ? 256'd19 : 256'd0);
    if (b >= FE_P) b = b - FE_P;
    return b;
  endfunction
endpackage

// Z^-1 = Z^(p-2) by left-to-right square-and-multiply on the shared multiplier.
module fe_invert
  import ge_fe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [319:0] z,
  output logic         done,
  output logic [319:0] recip,
  output logic [319:0] pmul_a,
  output logic [319:0] pmul_b,
  output logic         pmul_valid,
  input  logic [319:0] pmul_res,
  input  logic         pmul_done,
  output logic [2:0]   dbg_state
);
  typedef enum logic [2:0] {
    I_IDLE, I_SQ, I_SQ_WAIT, I_MUL, I_MUL_WAIT, I_DONE
  } istate_t;

  istate_t      state, state_nxt;
  logic [319:0] zr;
  logic [319:0] r;
  logic [7:0]   idx;
  logic         ebit;

  // p-2 = 2^255-21: every exponent bit below 255 is set except bits 2 and 4.
  assign ebit       = !((idx == 8'd2) || (idx == 8'd4));
  assign done       = (state == I_DONE);
  assign recip      = r;
  assign pmul_valid = (state == I_SQ) || (state == I_MUL);
  assign dbg_state  = state;

  always_comb begin
    pmul_a = '0;
    pmul_b = '0;
    case (state)
      I_SQ, I_SQ_WAIT: begin
        pmul_a = r;
        pmul_b = r;
      end
      I_MUL, I_MUL_WAIT: begin
        pmul_a = r;
        pmul_b = zr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      I_IDLE:     if (valid) state_nxt = I_SQ;
      I_SQ:       state_nxt = I_SQ_WAIT;
      I_SQ_WAIT:  if (pmul_done) state_nxt = ebit ? I_MUL : ((idx == 8'd0) ? I_DONE : I_SQ);
      I_MUL:      state_nxt = I_MUL_WAIT;
      I_MUL_WAIT: if (pmul_done) state_nxt = (idx == 8'd0) ? I_DONE : I_SQ;
      I_DONE:     state_nxt = I_IDLE;
      default:    state_nxt = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= I_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zr  <= '0;
      r   <= '0;
      idx <= '0;
    end else begin
      case (state)
        I_IDLE: if (valid) begin
          zr  <= z;
          r   <= FE_ONE;
          idx <= 8'd254;
        end
        I_SQ_WAIT: if (pmul_done) begin
          r <= pmul_res;
          if (!ebit && idx != 8'd0) idx <= idx - 8'd1;
        end
        I_MUL_WAIT: if (pmul_done) begin
          r <= pmul_res;
          if (idx != 8'd0) idx <= idx - 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

module ge_tobytes
  import ge_fe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] h_x,
  input  logic [319:0] h_y,
  input  logic [319:0] h_z,
  input  logic         valid,
  output logic [255:0] s,
  output logic         busy,
  output logic         done,
  output logic [319:0] mul_op_a,
  output logic [319:0] mul_op_b,
  output logic         mul_valid,
  input  logic [319:0] mul_res,
  input  logic         mul_done,
  output logic [2:0]   dbg_state,
  output logic [2:0]   dbg_inv_state
);
  // Multiplier handshake: a request is a one-cycle mul_valid pulse; operands stay
  // stable until the matching one-cycle mul_done; only one request is ever outstanding.
  typedef enum logic [2:0] {
    S_IDLE, S_INV_GO, S_INV_WAIT, S_MUL_X, S_WAIT_X, S_MUL_Y, S_WAIT_Y, S_PACK
  } state_t;

  state_t       state, state_nxt;
  logic [319:0] xr, yr, zr, recip, x_aff, y_aff;
  logic         inv_en;
  logic         inv_start, inv_done, inv_mvalid, inv_mdone;
  logic [319:0] inv_recip, inv_a, inv_b;
  logic [255:0] x_enc, y_enc, s_next;

  assign inv_start = (state == S_INV_GO);
  assign inv_mdone = mul_done & inv_en;
  assign dbg_state = state;

  fe_invert u_inv (
    .clk        (clk),
    .rst        (rst),
    .valid      (inv_start),
    .z          (zr),
    .done       (inv_done),
    .recip      (inv_recip),
    .pmul_a     (inv_a),
    .pmul_b     (inv_b),
    .pmul_valid (inv_mvalid),
    .pmul_res   (mul_res),
    .pmul_done  (inv_mdone),
    .dbg_state  (dbg_inv_state)
  );

  assign mul_valid = (state == S_MUL_X) || (state == S_MUL_Y) || (inv_en && inv_mvalid);

  always_comb begin
    mul_op_a = '0;
    mul_op_b = '0;
    if (inv_en) begin
      mul_op_a = inv_a;
      mul_op_b = inv_b;
    end else begin
      case (state)
        S_MUL_X, S_WAIT_X: begin
          mul_op_a = xr;
          mul_op_b = recip;
        end
        S_MUL_Y, S_WAIT_Y: begin
          mul_op_a = yr;
          mul_op_b = recip;
        end
        default: ;
      endcase
    end
  end

  // y_enc < p so its bit 255 is zero; the sign of x (its parity) lands there.
  assign x_enc  = fe_tobytes(x_aff);
  assign y_enc  = fe_tobytes(y_aff);
  assign s_next = y_enc | (x_enc << 255);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (valid) state_nxt = S_INV_GO;
      S_INV_GO:   state_nxt = S_INV_WAIT;
      S_INV_WAIT: if (inv_done) state_nxt = S_MUL_X;
      S_MUL_X:    state_nxt = S_WAIT_X;
      S_WAIT_X:   if (mul_done) state_nxt = S_MUL_Y;
      S_MUL_Y:    state_nxt = S_WAIT_Y;
      S_WAIT_Y:   if (mul_done) state_nxt = S_PACK;
      S_PACK:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      recip  <= '0;
      x_aff  <= '0;
      y_aff  <= '0;
      inv_en <= 1'b0;
      s      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (valid) begin
          xr   <= h_x;
          yr   <= h_y;
          zr   <= h_z;
          busy <= 1'b1;
        end
        S_INV_GO: inv_en <= 1'b1;
        S_INV_WAIT: if (inv_done) begin
          recip  <= inv_recip;
          inv_en <= 1'b0;
        end
        S_WAIT_X: if (mul_done) x_aff <= mul_res;
        S_WAIT_Y: if (mul_done) y_aff <= mul_res;
        S_PACK: begin
          s    <= s_next;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
